// File: rtl/median_window_sched.sv
// Streaming 3x3 median scheduler: buffers two lines, forms each interior window,
// runs the external median engine once per window and returns one result per window.
module median_window_sched #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int TMO   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  pix_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        eng_en_o,
    output logic [71:0] eng_win_o,
    input  logic        eng_done_i,
    input  logic [7:0]  eng_res_i,
    output logic [7:0]  res_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [TW-1:0] timer_q;
    logic [7:0]    line0_q [IMG_W];
    logic [7:0]    line1_q [IMG_W];
    logic [7:0]    win_q [9];
    logic [7:0]    res_q;
    logic          last_q, err_q, fd_q;
    logic          accept, at_last, win_full;

    assign accept   = (state_q == S_ACCEPT) && pix_valid_i;
    assign at_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign win_full = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
    end

    // Line buffers carry no reset: their contents only matter once refilled by a frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            line1_q[col_q] <= line0_q[col_q];
            line0_q[col_q] <= pix_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            timer_q <= '0;
            res_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            fd_q    <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_ACCEPT;
                        col_q   <= '0;
                        row_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (pix_valid_i) begin
                        // Window slides left; the new right column is (r-2, r-1, r) at this col.
                        win_q[0] <= win_q[1];
                        win_q[1] <= win_q[2];
                        win_q[2] <= line1_q[col_q];
                        win_q[3] <= win_q[4];
                        win_q[4] <= win_q[5];
                        win_q[5] <= line0_q[col_q];
                        win_q[6] <= win_q[7];
                        win_q[7] <= win_q[8];
                        win_q[8] <= pix_i;
                        col_q    <= col_d;
                        row_q    <= row_d;
                        last_q   <= at_last;
                        if (win_full) begin
                            state_q <= S_ISSUE;
                        end else if (at_last) begin
                            state_q <= S_IDLE;
                            fd_q    <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still counts as a real result.
                    if (eng_done_i) begin
                        res_q   <= eng_res_i;
                        state_q <= S_OUT;
                    end else if (timer_q == TMO_LAST) begin
                        res_q   <= 8'h00;
                        err_q   <= 1'b1;
                        state_q <= S_OUT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready_i) begin
                        if (last_q) begin
                            state_q <= S_IDLE;
                            fd_q    <= 1'b1;
                        end else begin
                            state_q <= S_ACCEPT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_ready_o  = (state_q == S_ACCEPT);
    assign busy_o       = (state_q != S_IDLE);
    assign eng_en_o     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign res_valid_o  = (state_q == S_OUT);
    assign res_o        = res_q;
    assign frame_done_o = fd_q;
    assign err_o        = err_q;
    assign eng_win_o    = {win_q[8], win_q[7], win_q[6], win_q[5], win_q[4],
                           win_q[3], win_q[2], win_q[1], win_q[0]};

endmodule

// File: tb/tb_median_window_sched.sv
// Bench for median_window_sched on a 4x4 frame: behavioural engine model,
// expected-result queue, frame table plus window-order and reset-abort sequences.
module tb_median_window_sched;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int TMO = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_main, noise_start, start_i;
  logic [7:0]  pix_i;
  logic        pix_valid_i, pix_ready_o;
  logic        eng_en_o, eng_done_i;
  logic [71:0] eng_win_o;
  logic [7:0]  eng_res_i, res_o;
  logic        res_valid_o, res_ready_i;
  logic        busy_o, frame_done_o, err_o;

  assign start_i = start_main | noise_start;

  median_window_sched #(.IMG_W(W), .IMG_H(H), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .eng_en_o(eng_en_o), .eng_win_o(eng_win_o),
    .eng_done_i(eng_done_i), .eng_res_i(eng_res_i), .res_o(res_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          eng_mode = 0;
  bit          rdy_rand = 0;
  bit          noise_en = 0;
  bit          aborting = 0;
  int          fd_cnt = 0;
  int          res_cnt = 0;
  logic [7:0]  img [W*H];
  logic [7:0]  exp_q [$];
  logic [71:0] win_log [$];

  typedef struct {
    int kind;      // 0: ramp 0..15, 1: random pixels
    int mode;      // engine: 0 median after 3, 1 centre random delay, 2 never, 3 done on timeout cycle
    bit rr;        // random res_ready_i
    bit nz;        // stray start_i pulses while busy
    bit exp_err;
    int exp_res;
  } frame_vec_t;

  function automatic void check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  function automatic logic [7:0] median72(input logic [71:0] w);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int k = 0; k < 9; k++) v[k] = w[k*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  function automatic logic [7:0] exp_result(input int r, input int c, input int mode);
    logic [71:0] w;
    if (mode == 2) return 8'h00;
    if (mode != 0) return img[(r-1)*W + c-1];
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = img[(r-2+k/3)*W + c-2+k%3];
    return median72(w);
  endfunction

  // engine model
  initial begin : engine
    int en_cnt, eng_delay;
    logic [71:0] win_issue;
    bit win_moved;
    en_cnt = 0; eng_delay = 0; win_issue = '0; win_moved = 0;
    eng_done_i = 1'b0; eng_res_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      eng_done_i = 1'b0;
      if (eng_en_o) begin
        if (en_cnt == 0) begin
          eng_delay = (eng_mode == 0) ? 3 : (eng_mode == 1) ? int'($urandom_range(1, 20)) : TMO;
          win_issue = eng_win_o;
          win_moved = 0;
          win_log.push_back(eng_win_o);
        end else if (eng_win_o !== win_issue) begin
          win_moved = 1;
        end
        en_cnt++;
        if (eng_mode != 2 && en_cnt == eng_delay + 1) begin
          eng_done_i = 1'b1;
          eng_res_i  = (eng_mode == 0) ? median72(eng_win_o) : eng_win_o[39:32];
        end
      end else if (en_cnt != 0) begin
        if (!aborting) begin
          check("en_cycles", en_cnt, (eng_mode == 2) ? TMO + 1 : eng_delay + 1);
          check("valid_after_done", res_valid_o, 1);
          check("win_stable", win_moved, 0);
        end
        en_cnt = 0;
      end
    end
  end

  initial begin : ready_gen
    res_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : start_noise
    noise_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      noise_start = noise_en && busy_o && ($urandom_range(0, 3) == 0);
    end
  end

  // scoreboard / monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (res_valid_o && res_ready_i) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %0h with no result expected", res_o);
        end else begin
          check("result", res_o, exp_q.pop_front());
        end
      end
      if (res_valid_o) check("en_low_in_out", eng_en_o, 0);
      if (frame_done_o) begin
        fd_cnt++;
        check("done_after_last_result", exp_q.size(), 0);
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1; start_main = 1'b1;
    @(posedge clk); #1; start_main = 1'b0;
  endtask

  task automatic drive_pixel(input logic [7:0] p);
    int n;
    n = 0;
    pix_i = p;
    pix_valid_i = 1'b1;
    @(negedge clk);
    while (!pix_ready_o && n < 300) begin @(negedge clk); n++; end
    if (!pix_ready_o) begin
      n_checks++;
      $display("FAIL pixel_accept_timeout: ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
  endtask

  task automatic run_frame(input int kind, input int mode, input bit rr, input bit nz,
                           input bit exp_err, input int exp_res);
    int base_res, budget;
    eng_mode = mode;
    rdy_rand = rr;
    for (int i = 0; i < W*H; i++)
      img[i] = (kind == 0) ? 8'(i) : (kind == 1) ? 8'($urandom_range(0, 255))
                                                 : 8'((i/W)*10 + 10 + (i%W));
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) exp_q.push_back(exp_result(r, c, mode));
    win_log.delete();
    fd_cnt = 0;
    base_res = res_cnt;
    pulse_start();
    check("err_cleared_by_start", err_o, 0);
    check("busy_after_start", busy_o, 1);
    noise_en = nz;
    for (int i = 0; i < W*H; i++) drive_pixel(img[i]);
    budget = 0;
    while ((exp_q.size() != 0 || fd_cnt == 0) && budget < 3000) begin
      @(negedge clk); #1; budget++;
    end
    noise_en = 0;
    if (budget >= 3000) begin
      n_checks++;
      $display("FAIL frame_timeout: %0d results outstanding, frame_done seen %0d", exp_q.size(), fd_cnt);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    rdy_rand = 0;
    check("frame_done_count", fd_cnt, 1);
    check("err_after_frame", err_o, exp_err);
    check("result_count", res_cnt - base_res, exp_res);
    check("idle_after_frame", busy_o, 0);
  endtask

  frame_vec_t vecs [6];

  initial begin : main
    vecs[0] = '{kind: 0, mode: 0, rr: 0, nz: 0, exp_err: 0, exp_res: 4};
    vecs[1] = '{kind: 0, mode: 1, rr: 1, nz: 0, exp_err: 0, exp_res: 4};
    vecs[2] = '{kind: 1, mode: 0, rr: 1, nz: 0, exp_err: 0, exp_res: 4};
    vecs[3] = '{kind: 0, mode: 2, rr: 0, nz: 0, exp_err: 1, exp_res: 4};
    vecs[4] = '{kind: 0, mode: 3, rr: 0, nz: 0, exp_err: 0, exp_res: 4};
    vecs[5] = '{kind: 1, mode: 1, rr: 1, nz: 1, exp_err: 0, exp_res: 4};

    rst = 1'b1; start_main = 1'b0; pix_i = 8'h00; pix_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pix_ready", pix_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_eng_en", eng_en_o, 0);
    check("rst_eng_win", eng_win_o, 72'h0);
    check("rst_res", res_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_err", err_o, 0);

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].kind, vecs[v].mode, vecs[v].rr, vecs[v].nz, vecs[v].exp_err, vecs[v].exp_res);

    // window ordering: rows 10..13, 20..23, 30..33
    run_frame(2, 1, 0, 0, 0, 4);
    check("win_at_2_2", win_log.size() > 0 ? win_log[0] : 72'h0, 72'h20_1f_1e_16_15_14_0c_0b_0a);
    check("win_at_2_3", win_log.size() > 1 ? win_log[1] : 72'h0, 72'h21_20_1f_17_16_15_0d_0c_0b);

    // reset while waiting on the engine
    begin
      int base_res;
      eng_mode = 2;
      base_res = res_cnt;
      pulse_start();
      for (int i = 0; i < 11; i++) drive_pixel(8'(i));
      repeat (3) begin @(posedge clk); #1; end
      check("en_before_rst", eng_en_o, 1);
      aborting = 1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_eng_en", eng_en_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_res_valid", res_valid_o, 0);
      repeat (4) @(negedge clk);
      aborting = 0;
      check("abort_no_result", res_cnt - base_res, 0);
    end
    run_frame(1, 0, 1, 0, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
